regfile_sb: RTL and testbench

Parametrised integer register file with a per-register busy-bit scoreboard for the in-order pipeline. It provides a configurable number of asynchronous read ports, one synchronous write port and one issue port that marks a destination register as pending until its writeback arrives. It sits between decode/issue, which reads operands and checks hazards, and writeback, which writes results and clears pending flags.

---
 rtl/regfile_sb.sv | 90 +++++++++
 tb/tb_regfile_sb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard for in-order issue.
// Define REGFILE_BYPASS_EN to forward the writeback port to reads and issue_ready in the same cycle.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW:0]      cnt;
  logic             wr_en;
  logic             iss_zero;
  logic             iss_acc;
  logic             set_inc;
  logic             clr_dec;

  assign wr_en    = we && !((ZERO_REG != 0) && (wa == '0));
  assign iss_zero = (ZERO_REG != 0) && (issue_rd == '0);

  always_comb begin
    issue_ready = iss_zero || !busy[issue_rd];
`ifdef REGFILE_BYPASS_EN
    if (we && (issue_rd == wa)) issue_ready = 1'b1;
`endif
  end

  assign iss_acc = issue_valid && issue_ready && !iss_zero;
  assign set_inc = iss_acc && !busy[issue_rd];
  // A same-cycle issue to the written register keeps the bit set, so no decrement.
  assign clr_dec = wr_en && busy[wa] && !(iss_acc && (issue_rd == wa));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      cnt  <= '0;
    end else if (flush) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en)   busy[wa]       <= 1'b0;
      if (iss_acc) busy[issue_rd] <= 1'b1;
      cnt <= cnt + {{AW{1'b0}}, set_inc} - {{AW{1'b0}}, clr_dec};
    end
  end

  assign busy_cnt = cnt;

  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!((ZERO_REG != 0) && (ra[i*AW +: AW] == '0))) begin
        rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
        rbusy[i]           = busy[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wa == ra[i*AW +: AW])) begin
          rd[i*XLEN +: XLEN] = wd;
          rbusy[i]           = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default parameters); expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        flush;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rbusy(rbusy), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .flush(flush), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; wa = '0; wd = '0; issue_valid = 0; issue_rd = '0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); ra = '0;
    #2;
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, issue_ready} !== exp) begin errors++; $display("FAIL por_issue_ready got %0d exp %0d", issue_ready, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL por_busy_cnt got %0d exp %0d", busy_cnt, exp); end
    tick(); rst_n = 1; tick();
    // write reg5 then mark it busy
    we = 1; wa = 5; wd = 32'hDEADBEEF; tick(); idle();
    issue_valid = 1; issue_rd = 5; tick(); idle();
    ra = {5'd5, 5'd5}; issue_rd = 5; #1;
    exp_q.push_back(32'hDEADBEEF);
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp) begin errors++; $display("FAIL pre_rst_rd got %h exp %h", rd[31:0], exp); end
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL pre_rst_cnt got %0d exp %0d", busy_cnt, exp); end
    rst_n = 0; #1;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if ({rd[63:32] | rd[31:0]} !== exp) begin errors++; $display("FAIL mid_rst_rd got %h exp %h", rd, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp || rbusy !== 2'b00) begin errors++; $display("FAIL mid_rst_busy got cnt %0d rbusy %b exp %0d", busy_cnt, rbusy, exp); end
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, issue_ready} !== exp) begin errors++; $display("FAIL mid_rst_ready got %0d exp %0d", issue_ready, exp); end
    tick(); rst_n = 1; tick();
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp || rbusy !== 2'b00 || busy_cnt !== 6'd0) begin errors++; $display("FAIL post_rst got rd %h rbusy %b cnt %0d exp %h", rd[31:0], rbusy, busy_cnt, exp); end
  endtask

  task automatic test_write_read();
    idle(); ra = '0;
    we = 1; wa = 3; wd = 32'h12345678; exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    tick(); idle(); ra = {5'd3, 5'd3}; #1;
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp) begin errors++; $display("FAIL wr_rd0 got %h exp %h", rd[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd[63:32] !== exp) begin errors++; $display("FAIL wr_rd1 got %h exp %h", rd[63:32], exp); end
    ra = '0; we = 1; wa = 0; wd = 32'hFFFFFFFF; exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp) begin errors++; $display("FAIL zero_wr_same got %h exp %h", rd[31:0], exp); end
    tick(); idle(); ra = '0; exp_q.push_back(32'd0); #1;
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp || rbusy[0] !== 1'b0) begin errors++; $display("FAIL zero_wr got %h busy %b exp %h", rd[31:0], rbusy[0], exp); end
  endtask

  task automatic test_scoreboard();
    idle(); ra = '0;
    issue_valid = 1; issue_rd = 7; #1;
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, issue_ready} !== exp) begin errors++; $display("FAIL sb_ready_pre got %0d exp %0d", issue_ready, exp); end
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    tick(); idle(); issue_rd = 7; ra = {5'd0, 5'd7}; #1;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, issue_ready} !== exp) begin errors++; $display("FAIL sb_ready_post got %0d exp %0d", issue_ready, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, rbusy[0]} !== exp) begin errors++; $display("FAIL sb_rbusy got %0d exp %0d", rbusy[0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL sb_cnt got %0d exp %0d", busy_cnt, exp); end
    we = 1; wa = 7; wd = 32'h00000077;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h77);
    tick(); idle(); issue_rd = 7; ra = {5'd0, 5'd7}; #1;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, rbusy[0]} !== exp) begin errors++; $display("FAIL sb_clr_rbusy got %0d exp %0d", rbusy[0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL sb_clr_cnt got %0d exp %0d", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp || issue_ready !== 1'b1) begin errors++; $display("FAIL sb_clr_data got %h ready %0d exp %h", rd[31:0], issue_ready, exp); end
  endtask

  task automatic test_simultaneous();
    idle(); ra = '0;
    we = 1; wa = 4; wd = 32'h44444444; issue_valid = 1; issue_rd = 4;
    exp_q.push_back(32'h44444444); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    tick(); idle(); ra = {5'd0, 5'd4}; #1;
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp) begin errors++; $display("FAIL same_data got %h exp %h", rd[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, rbusy[0]} !== exp) begin errors++; $display("FAIL same_busy got %0d exp %0d", rbusy[0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL same_cnt got %0d exp %0d", busy_cnt, exp); end
    issue_valid = 1; issue_rd = 9; flush = 1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick(); idle(); ra = {5'd9, 5'd4}; #1;
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rbusy} !== exp) begin errors++; $display("FAIL flush_busy got %b exp %0d", rbusy, exp); end
  endtask

  task automatic test_bypass();
    idle(); ra = '0;
    we = 1; wa = 2; wd = 32'h11111111; tick(); idle();
    issue_valid = 1; issue_rd = 2; tick(); idle();
    we = 1; wa = 2; wd = 32'hA5A5A5A5; ra = {5'd0, 5'd2}; issue_rd = 2;
    exp_q.push_back(BYP ? 32'hA5A5A5A5 : 32'h11111111);
    exp_q.push_back(BYP ? 32'd0 : 32'd1);
    exp_q.push_back(BYP ? 32'd1 : 32'd0);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp) begin errors++; $display("FAIL byp_rd got %h exp %h", rd[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, rbusy[0]} !== exp) begin errors++; $display("FAIL byp_rbusy got %0d exp %0d", rbusy[0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, issue_ready} !== exp) begin errors++; $display("FAIL byp_ready got %0d exp %0d", issue_ready, exp); end
    exp_q.push_back(32'hA5A5A5A5);
    tick(); idle(); ra = {5'd0, 5'd2}; #1;
    exp = exp_q.pop_front(); checks++;
    if (rd[31:0] !== exp || rbusy[0] !== 1'b0 || busy_cnt !== 6'd0) begin errors++; $display("FAIL byp_after got %h busy %0d cnt %0d exp %h", rd[31:0], rbusy[0], busy_cnt, exp); end
  endtask

  task automatic test_saturation();
    idle(); ra = '0;
    for (int r = 1; r < 32; r++) begin
      issue_valid = 1; issue_rd = 5'(r); tick();
    end
    idle(); issue_rd = 31; exp_q.push_back(32'd31); #1;
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp || issue_ready !== 1'b0) begin errors++; $display("FAIL sat_full got cnt %0d ready %0d exp %0d", busy_cnt, issue_ready, exp); end
    issue_valid = 1; issue_rd = 0; exp_q.push_back(32'd1); #1;
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, issue_ready} !== exp) begin errors++; $display("FAIL sat_zero_ready got %0d exp %0d", issue_ready, exp); end
    tick(); idle();
    for (int r = 1; r < 32; r++) begin
      we = 1; wa = 5'(r); wd = 32'(r); exp_q.push_back(32'(31 - r));
      tick(); idle();
      exp = exp_q.pop_front(); checks++;
      if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL sat_drain_%0d got %0d exp %0d", r, busy_cnt, exp); end
    end
    we = 1; wa = 5; wd = 32'h55; exp_q.push_back(32'd0);
    tick(); idle();
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL sat_nowrap got %0d exp %0d", busy_cnt, exp); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
